// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-interface types for the processor-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W       = 32;
  localparam int BLOCK_W      = 64;
  localparam int MEM_TAG_W    = 4;
  localparam int NUM_MEM_TAGS = 15;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  typedef logic [MEM_TAG_W-1:0] MEM_TAG;
  typedef logic [BLOCK_W-1:0]   MEM_BLOCK;
  typedef logic [ADDR_W-1:0]    ADDR;

  typedef struct packed {
    logic valid;
    logic is_icache;
  } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tracks which requester owns each outstanding memory tag; a response frees its entry
// on the next edge, and an allocation to the same tag in that cycle takes precedence.
module mem_tag_owner_table
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  logic                 alloc_is_icache,
  input  logic [MEM_TAG_W-1:0] lookup_tag,
  output logic                 hit,
  output logic                 hit_is_icache
);

  MEM_OWNER_ENTRY owner [1:NUM_TAGS];
  logic           alloc_live;

  always_comb begin
    hit           = 1'b0;
    hit_is_icache = 1'b0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (!reset && lookup_tag == MEM_TAG_W'(i) && owner[i].valid) begin
        hit           = 1'b1;
        hit_is_icache = owner[i].is_icache;
      end
    end
  end

  // A live entry being freed by this cycle's response is a legal reuse, not an overwrite.
  always_comb begin
    alloc_live = 1'b0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (alloc_tag == MEM_TAG_W'(i) && owner[i].valid && !(hit && lookup_tag == alloc_tag))
        alloc_live = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i <= NUM_TAGS; i++) owner[i] <= '0;
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        if (hit && lookup_tag == MEM_TAG_W'(i)) owner[i].valid <= 1'b0;
        if (alloc_en && alloc_tag == MEM_TAG_W'(i)) owner[i] <= {1'b1, alloc_is_icache};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (lookup_tag != '0)
        assert (hit) else $warning("response tag %0d has no owner, dropped", lookup_tag);
      if (alloc_en)
        assert (!alloc_live) else $warning("tag %0d reallocated while still owned", alloc_tag);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single processor-memory port between D-cache MSHR and I-cache fetch, and
// routes transaction and response tags back to their owners. MEM_ARB_ROUND_ROBIN_EN selects round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = NUM_MEM_TAGS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           dc_command,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [BLOCK_W-1:0]   dc_data,
  input  logic [1:0]           ic_command,
  input  logic [ADDR_W-1:0]    ic_addr,
  input  logic [MEM_TAG_W-1:0] mem2proc_transaction_tag,
  input  logic [BLOCK_W-1:0]   mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_data_tag,
  output logic [1:0]           proc2mem_command,
  output logic [ADDR_W-1:0]    proc2mem_addr,
  output logic [BLOCK_W-1:0]   proc2mem_data,
  output logic [MEM_TAG_W-1:0] dc_transaction_tag,
  output logic [MEM_TAG_W-1:0] ic_transaction_tag,
  output logic [MEM_TAG_W-1:0] dc_data_tag,
  output logic [MEM_TAG_W-1:0] ic_data_tag,
  output logic [BLOCK_W-1:0]   resp_data
);

  logic dc_req;
  logic ic_req;
  logic grant_dc;
  logic grant_ic;
  logic alloc_en;
  logic hit;
  logic hit_is_icache;

  assign dc_req = (dc_command != MEM_NONE);
  assign ic_req = (ic_command != MEM_NONE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_ic;

  // Reset to I-cache so the D-cache wins the first tie.
  always_ff @(posedge clock) begin
    if (reset)         last_grant_ic <= 1'b1;
    else if (grant_dc) last_grant_ic <= 1'b0;
    else if (grant_ic) last_grant_ic <= 1'b1;
  end

  assign grant_ic = ic_req && (!dc_req || !last_grant_ic);
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved  = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_ic = ic_req && (!dc_req || starved);

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (ic_req && !grant_ic) begin
      if (!starved) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  assign grant_dc = dc_req && !grant_ic;

  always_comb begin
    proc2mem_command   = MEM_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    dc_transaction_tag = '0;
    ic_transaction_tag = '0;
    if (!reset) begin
      if (grant_dc) begin
        proc2mem_command   = dc_command;
        proc2mem_addr      = dc_addr;
        proc2mem_data      = dc_data;
        dc_transaction_tag = mem2proc_transaction_tag;
      end else if (grant_ic) begin
        proc2mem_command   = ic_command;
        proc2mem_addr      = ic_addr;
        ic_transaction_tag = mem2proc_transaction_tag;
      end
    end
  end

  // Stores never get a data response, so only accepted loads take an owner entry.
  assign alloc_en = !reset && (mem2proc_transaction_tag != '0) &&
                    ((grant_dc && dc_command == MEM_LOAD) || (grant_ic && ic_command == MEM_LOAD));

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock           (clock),
    .reset           (reset),
    .alloc_en        (alloc_en),
    .alloc_tag       (mem2proc_transaction_tag),
    .alloc_is_icache (grant_ic),
    .lookup_tag      (mem2proc_data_tag),
    .hit             (hit),
    .hit_is_icache   (hit_is_icache)
  );

  assign dc_data_tag = (hit && !hit_is_icache) ? mem2proc_data_tag : '0;
  assign ic_data_tag = (hit &&  hit_is_icache) ? mem2proc_data_tag : '0;
  assign resp_data   = reset ? '0 : mem2proc_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of the memory-port arbiter against a tag-ownership model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  dc_cmd, ic_cmd;
  logic [31:0] dc_addr, ic_addr;
  logic [63:0] dc_data, mdata;
  logic [3:0]  mtag, mdtag;

  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data, resp_data;
  logic [3:0]  dc_transaction_tag, ic_transaction_tag, dc_data_tag, ic_data_tag;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  bit [15:0] m_valid;
  bit [15:0] m_is_ic;
  int        m_lost;
  bit        m_last_ic;

  logic [1:0]  o_cmd;
  logic [31:0] o_addr;
  logic [63:0] o_data, o_resp;
  logic [3:0]  o_dct, o_ict, o_dcd, o_icd;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .NUM_TAGS(15)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .dc_command               (dc_cmd),
    .dc_addr                  (dc_addr),
    .dc_data                  (dc_data),
    .ic_command               (ic_cmd),
    .ic_addr                  (ic_addr),
    .mem2proc_transaction_tag (mtag),
    .mem2proc_data            (mdata),
    .mem2proc_data_tag        (mdtag),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .dc_transaction_tag       (dc_transaction_tag),
    .ic_transaction_tag       (ic_transaction_tag),
    .dc_data_tag              (dc_data_tag),
    .ic_data_tag              (ic_data_tag),
    .resp_data                (resp_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pick_free(input bit rnd);
    logic [3:0] q[$];
    for (int t = 1; t <= 15; t++) if (!m_valid[t]) q.push_back(4'(t));
    if (q.size() == 0) return 4'd0;
    return rnd ? q[$urandom_range(0, q.size() - 1)] : q[0];
  endfunction

  function automatic logic [3:0] pick_valid(input bit rnd);
    logic [3:0] q[$];
    for (int t = 1; t <= 15; t++) if (m_valid[t]) q.push_back(4'(t));
    if (q.size() == 0) return 4'd0;
    return rnd ? q[$urandom_range(0, q.size() - 1)] : q[0];
  endfunction

  // Called just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step(input string name);
    bit dreq, ireq, i_wins, d_wins, owned;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_data, e_resp;
    logic [3:0]  e_dct, e_ict, e_dcd, e_icd;
    #2;
    dreq = (dc_cmd != MEM_NONE);
    ireq = (ic_cmd != MEM_NONE);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    i_wins = ireq && (!dreq || !m_last_ic);
`else
    i_wins = ireq && (!dreq || m_lost >= LIMIT);
`endif
    d_wins = dreq && !i_wins;
    owned  = (mdtag != 0) && m_valid[mdtag];
    e_cmd = MEM_NONE; e_addr = 0; e_data = 0; e_dct = 0; e_ict = 0; e_dcd = 0; e_icd = 0; e_resp = 0;
    if (!reset) begin
      if (d_wins) begin e_cmd = dc_cmd; e_addr = dc_addr; e_data = dc_data; e_dct = mtag; end
      if (i_wins) begin e_cmd = ic_cmd; e_addr = ic_addr; e_ict = mtag; end
      if (owned && m_is_ic[mdtag])  e_icd = mdtag;
      if (owned && !m_is_ic[mdtag]) e_dcd = mdtag;
      e_resp = mdata;
    end
    o_cmd = proc2mem_command; o_addr = proc2mem_addr; o_data = proc2mem_data; o_resp = resp_data;
    o_dct = dc_transaction_tag; o_ict = ic_transaction_tag; o_dcd = dc_data_tag; o_icd = ic_data_tag;
    check({name, ".cmd"},  64'(o_cmd),  64'(e_cmd));
    check({name, ".addr"}, 64'(o_addr), 64'(e_addr));
    check({name, ".data"}, o_data, e_data);
    check({name, ".dct"},  64'(o_dct),  64'(e_dct));
    check({name, ".ict"},  64'(o_ict),  64'(e_ict));
    check({name, ".dcd"},  64'(o_dcd),  64'(e_dcd));
    check({name, ".icd"},  64'(o_icd),  64'(e_icd));
    check({name, ".resp"}, o_resp, e_resp);
    @(posedge clock);
    if (reset) begin
      m_valid = '0; m_lost = 0; m_last_ic = 1'b1;
    end else begin
      if (owned) m_valid[mdtag] = 1'b0;
      if (mtag != 0 && ((d_wins && dc_cmd == MEM_LOAD) || (i_wins && ic_cmd == MEM_LOAD))) begin
        m_valid[mtag] = 1'b1;
        m_is_ic[mtag] = i_wins;
      end
      m_lost = (ireq && !i_wins) ? ((m_lost < LIMIT) ? m_lost + 1 : LIMIT) : 0;
      if (d_wins) m_last_ic = 1'b0;
      else if (i_wins) m_last_ic = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    dc_cmd = MEM_NONE; ic_cmd = MEM_NONE; dc_addr = 0; ic_addr = 0; dc_data = 0;
    mtag = 0; mdtag = 0; mdata = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 16; n++) begin
      if (m_valid == '0) break;
      idle_inputs();
      mdtag = pick_valid(1'b0);
      mdata = {$urandom, $urandom};
      step("drain");
    end
  endtask

  initial begin
    logic [3:0] t_held [3];
    m_valid = '0; m_is_ic = '0; m_lost = 0; m_last_ic = 1'b1;
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);

    // Requests and a response during reset are all suppressed.
    dc_cmd = MEM_LOAD; dc_addr = 32'h100; ic_cmd = MEM_LOAD; ic_addr = 32'h200;
    mtag = 4'd9; mdtag = 4'd4; mdata = 64'h55;
    step("rst0");
    step("rst1");
    reset = 1'b0;

    // Continuous contention from both requesters.
    for (int c = 0; c < 6; c++) begin
      dc_cmd = MEM_LOAD; dc_addr = (c == 0) ? 32'h100 : 32'h1000 + 32'(c);
      ic_cmd = MEM_LOAD; ic_addr = 32'h200;
      mdtag = 0; mdata = 0;
      mtag = (c == 0) ? 4'd3 : pick_free(1'b0);
      step("contend");
      if (c == 0) begin
        check("first_tie_addr", 64'(o_addr), 64'h100);
        check("first_tie_dct", 64'(o_dct), 64'd3);
        check("first_tie_ict", 64'(o_ict), 64'd0);
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (c == 1) begin
        check("rr_second_ict", 64'(o_ict), 64'(mtag));
        check("rr_second_dct", 64'(o_dct), 64'd0);
      end
      if (c == 2) check("rr_third_dct", 64'(o_dct), 64'(mtag));
`else
      if (c == 4) begin
        check("starve_ict", 64'(o_ict), 64'(mtag));
        check("starve_dct", 64'(o_dct), 64'd0);
      end
      if (c == 5) check("after_starve_dct", 64'(o_dct), 64'(mtag));
`endif
    end
    drain();

    // I-cache load on tag 5, its response, then a repeat that must be dropped.
    idle_inputs(); ic_cmd = MEM_LOAD; ic_addr = 32'h300; mtag = 4'd5;
    step("ic_load5");
    check("ic_load5_ict", 64'(o_ict), 64'd5);
    idle_inputs(); mdtag = 4'd5; mdata = 64'hDEAD;
    step("resp5");
    check("resp5_icd", 64'(o_icd), 64'd5);
    check("resp5_dcd", 64'(o_dcd), 64'd0);
    check("resp5_data", o_resp, 64'hDEAD);
    step("resp5_again");
    check("resp5_again_icd", 64'(o_icd), 64'd0);

    // D-cache store takes no owner entry.
    idle_inputs(); dc_cmd = MEM_STORE; dc_addr = 32'h400; dc_data = 64'h1234; mtag = 4'd2;
    step("store2");
    check("store2_cmd", 64'(o_cmd), 64'(MEM_STORE));
    check("store2_data", o_data, 64'h1234);
    idle_inputs(); mdtag = 4'd2;
    step("stray2");
    check("stray2_dcd", 64'(o_dcd), 64'd0);

    // Tag 7 freed by an I-cache response and reused by a D-cache load in the same cycle.
    idle_inputs(); ic_cmd = MEM_LOAD; ic_addr = 32'h700; mtag = 4'd7;
    step("ic_load7");
    idle_inputs(); dc_cmd = MEM_LOAD; dc_addr = 32'h500; mtag = 4'd7; mdtag = 4'd7;
    step("swap7");
    check("swap7_icd", 64'(o_icd), 64'd7);
    check("swap7_dct", 64'(o_dct), 64'd7);
    idle_inputs(); mdtag = 4'd7;
    step("resp7");
    check("resp7_dcd", 64'(o_dcd), 64'd7);
    check("resp7_icd", 64'(o_icd), 64'd0);
    drain();

    // Reset with three loads outstanding clears ownership.
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); dc_cmd = MEM_LOAD; dc_addr = 32'h800 + 32'(k); mtag = pick_free(1'b1);
      t_held[k] = mtag;
      step("hold");
    end
    idle_inputs(); reset = 1'b1; mdtag = t_held[0];
    step("rst_held");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); mdtag = t_held[k]; mdata = 64'hBEEF;
      step("after_rst");
      check("after_rst_dcd", 64'(o_dcd), 64'd0);
    end

    // Random traffic obeying the memory protocol.
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 59) == 0);
      dc_cmd  = 2'($urandom_range(0, 2));
      ic_cmd  = ($urandom_range(0, 2) != 0) ? MEM_LOAD : MEM_NONE;
      dc_addr = $urandom; ic_addr = $urandom;
      dc_data = {$urandom, $urandom}; mdata = {$urandom, $urandom};
      mtag    = ($urandom_range(0, 3) == 0) ? 4'd0 : pick_free(1'b1);
      mdtag   = ($urandom_range(0, 1) == 0) ? 4'd0 : pick_valid(1'b1);
      step("rand");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
